// File: rtl/frame_buffer_scanner.sv
// frame_buffer_scanner: raster-order read controller for frame_buffer, streaming pixels through a
// 2-entry output FIFO on valid/ready. Define FRAME_SCANNER_COORD_EN to add per-pixel O_PIXEL_COL/O_PIXEL_ROW.
module frame_buffer_scanner #(
    parameter int unsigned P_COLUMNS     = 640,
    parameter int unsigned P_ROWS        = 3,
    parameter int unsigned P_PIXEL_DEPTH = 24
) (
    input  logic                          I_CLK,
    input  logic                          I_RESET,
    input  logic                          I_ENABLE,
    input  logic                          I_START,
    output logic                          O_BUSY,
    output logic                          O_DONE,
    output logic [$clog2(P_COLUMNS)-1:0]  O_FB_COL,
    output logic [$clog2(P_ROWS)-1:0]     O_FB_ROW,
    output logic                          O_FB_READ_ENABLE,
    input  logic [P_PIXEL_DEPTH-1:0]      I_FB_PIXEL,
    output logic [P_PIXEL_DEPTH-1:0]      O_PIXEL,
    output logic                          O_VALID,
    input  logic                          I_READY,
    output logic                          O_LAST
`ifdef FRAME_SCANNER_COORD_EN
    ,
    output logic [$clog2(P_COLUMNS)-1:0]  O_PIXEL_COL,
    output logic [$clog2(P_ROWS)-1:0]     O_PIXEL_ROW
`endif
);
    localparam int unsigned COL_W = $clog2(P_COLUMNS);
    localparam int unsigned ROW_W = $clog2(P_ROWS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic                     inflight_q, inflight_d;
    logic                     infl_last_q, infl_last_d;
    logic [1:0]               occ_q, occ_d;
    logic                     wr_ptr_q, wr_ptr_d;
    logic                     rd_ptr_q, rd_ptr_d;
    logic [P_PIXEL_DEPTH-1:0] pix_mem_q [2];
    logic [P_PIXEL_DEPTH-1:0] pix_mem_d [2];
    logic                     last_mem_q [2];
    logic                     last_mem_d [2];
`ifdef FRAME_SCANNER_COORD_EN
    logic [COL_W-1:0]         infl_col_q, infl_col_d;
    logic [ROW_W-1:0]         infl_row_q, infl_row_d;
    logic [COL_W-1:0]         col_mem_q [2];
    logic [COL_W-1:0]         col_mem_d [2];
    logic [ROW_W-1:0]         row_mem_q [2];
    logic [ROW_W-1:0]         row_mem_d [2];
`endif

    logic       valid_c, pop_c, push_c, rd_en_c, last_addr_c, head_last_c;
    logic [2:0] level_c;

    // Handshake and read throttle; level counts FIFO entries plus the read landing this cycle.
    always_comb begin
        valid_c     = (occ_q != 2'd0) & I_ENABLE;
        head_last_c = last_mem_q[rd_ptr_q];
        pop_c       = valid_c & I_READY;
        push_c      = inflight_q & I_ENABLE;
        level_c     = 3'(occ_q) + 3'(inflight_q) - 3'(pop_c);
        last_addr_c = (col_q == COL_W'(P_COLUMNS - 1)) & (row_q == ROW_W'(P_ROWS - 1));
        rd_en_c     = (state_q == S_READ) & I_ENABLE & (level_c < 3'd2);
    end

    // Next-state, address and FIFO update; everything holds while I_ENABLE is low.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        inflight_d  = inflight_q;
        infl_last_d = infl_last_q;
        occ_d       = occ_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pix_mem_d   = pix_mem_q;
        last_mem_d  = last_mem_q;
`ifdef FRAME_SCANNER_COORD_EN
        infl_col_d  = infl_col_q;
        infl_row_d  = infl_row_q;
        col_mem_d   = col_mem_q;
        row_mem_d   = row_mem_q;
`endif
        if (I_ENABLE) begin
            inflight_d = rd_en_c;
            if (rd_en_c) begin
                infl_last_d = last_addr_c;
`ifdef FRAME_SCANNER_COORD_EN
                infl_col_d  = col_q;
                infl_row_d  = row_q;
`endif
            end
            case (state_q)
                S_IDLE: begin
                    if (I_START) state_d = S_READ;
                end
                S_READ: begin
                    if (rd_en_c) begin
                        if (last_addr_c) begin
                            state_d = S_DRAIN;
                            col_d   = '0;
                            row_d   = '0;
                        end else if (col_q == COL_W'(P_COLUMNS - 1)) begin
                            col_d = '0;
                            row_d = row_q + ROW_W'(1);
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop_c & head_last_c) state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    col_d   = '0;
                    row_d   = '0;
                end
                default: state_d = S_IDLE;
            endcase
            if (push_c) begin
                pix_mem_d[wr_ptr_q]  = I_FB_PIXEL;
                last_mem_d[wr_ptr_q] = infl_last_q;
`ifdef FRAME_SCANNER_COORD_EN
                col_mem_d[wr_ptr_q]  = infl_col_q;
                row_mem_d[wr_ptr_q]  = infl_row_q;
`endif
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop_c) rd_ptr_d = ~rd_ptr_q;
            occ_d = occ_q + 2'(push_c) - 2'(pop_c);
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET) begin
        if (!I_RESET) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            occ_q       <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                pix_mem_q[i]  <= '0;
                last_mem_q[i] <= 1'b0;
            end
`ifdef FRAME_SCANNER_COORD_EN
            infl_col_q <= '0;
            infl_row_q <= '0;
            for (int i = 0; i < 2; i++) begin
                col_mem_q[i] <= '0;
                row_mem_q[i] <= '0;
            end
`endif
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
            occ_q       <= occ_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pix_mem_q   <= pix_mem_d;
            last_mem_q  <= last_mem_d;
`ifdef FRAME_SCANNER_COORD_EN
            infl_col_q  <= infl_col_d;
            infl_row_q  <= infl_row_d;
            col_mem_q   <= col_mem_d;
            row_mem_q   <= row_mem_d;
`endif
        end
    end

    assign O_BUSY           = (state_q == S_READ) | (state_q == S_DRAIN);
    assign O_DONE           = (state_q == S_DONE);
    assign O_FB_COL         = col_q;
    assign O_FB_ROW         = row_q;
    assign O_FB_READ_ENABLE = rd_en_c;
    assign O_VALID          = valid_c;
    assign O_PIXEL          = pix_mem_q[rd_ptr_q];
    assign O_LAST           = valid_c & head_last_c;
`ifdef FRAME_SCANNER_COORD_EN
    assign O_PIXEL_COL      = col_mem_q[rd_ptr_q];
    assign O_PIXEL_ROW      = row_mem_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_frame_buffer_scanner.sv
// Bench for frame_buffer_scanner (4x3 frame): directed scenarios plus randomized ready/enable,
// checked every cycle against a transaction-level model of reads issued and pixels delivered.
module tb_frame_buffer_scanner;
    localparam int COLS = 4;
    localparam int ROWS = 3;
    localparam int PW   = 24;
    localparam int NPIX = COLS * ROWS;

    logic          clk = 1'b0;
    logic          I_RESET, I_ENABLE, I_START, I_READY;
    logic          O_BUSY, O_DONE, O_FB_READ_ENABLE, O_VALID, O_LAST;
    logic [1:0]    O_FB_COL;
    logic [1:0]    O_FB_ROW;
    logic [PW-1:0] O_PIXEL;
    logic [PW-1:0] fb_pixel = '0;
`ifdef FRAME_SCANNER_COORD_EN
    logic [1:0]    O_PIXEL_COL;
    logic [1:0]    O_PIXEL_ROW;
`endif

    always #5 clk = ~clk;

    frame_buffer_scanner #(.P_COLUMNS(COLS), .P_ROWS(ROWS), .P_PIXEL_DEPTH(PW)) dut (
        .I_CLK(clk), .I_RESET(I_RESET), .I_ENABLE(I_ENABLE), .I_START(I_START),
        .O_BUSY(O_BUSY), .O_DONE(O_DONE), .O_FB_COL(O_FB_COL), .O_FB_ROW(O_FB_ROW),
        .O_FB_READ_ENABLE(O_FB_READ_ENABLE), .I_FB_PIXEL(fb_pixel), .O_PIXEL(O_PIXEL),
        .O_VALID(O_VALID), .I_READY(I_READY), .O_LAST(O_LAST)
`ifdef FRAME_SCANNER_COORD_EN
        , .O_PIXEL_COL(O_PIXEL_COL), .O_PIXEL_ROW(O_PIXEL_ROW)
`endif
    );

    // frame_buffer stand-in: 1-cycle registered read, holds under the shared enable
    always_ff @(posedge clk)
        if (I_ENABLE && O_FB_READ_ENABLE)
            fb_pixel <= {8'hA0 | 8'(O_FB_ROW), 8'h00, 8'(O_FB_COL)};

    int checks = 0;
    int failures = 0;
    // transaction model: frame in progress, reads issued, pixels delivered
    bit scan_active, done_exp, inflight_m;
    int reads, xfers;
    int dut_reads, dut_xfers;
    bit s_valid, s_rden, s_done, s_busy;
    logic [1:0] s_col, s_row;
    logic [PW-1:0] s_pixel;

    function automatic logic [PW-1:0] pix(input int n);
        logic [7:0] r, c;
        r = 8'(n / COLS);
        c = 8'(n % COLS);
        return {8'hA0 | r, 8'h00, c};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        scan_active = 0; done_exp = 0; inflight_m = 0;
        reads = 0; xfers = 0; dut_reads = 0; dut_xfers = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(O_BUSY), 32'd0);
        check({tag, "_done"}, 32'(O_DONE), 32'd0);
        check({tag, "_col"},  32'(O_FB_COL), 32'd0);
        check({tag, "_row"},  32'(O_FB_ROW), 32'd0);
        check({tag, "_rden"}, 32'(O_FB_READ_ENABLE), 32'd0);
        check({tag, "_pix"},  32'(O_PIXEL), 32'd0);
        check({tag, "_valid"}, 32'(O_VALID), 32'd0);
        check({tag, "_last"}, 32'(O_LAST), 32'd0);
    endtask

    // Per-cycle comparison of DUT against the model, then advance the model.
    task automatic observe();
        bit idle_now, exp_valid, exp_rd, pop;
        int outstanding;
        idle_now    = !scan_active && !done_exp;
        outstanding = reads - xfers;
        exp_valid   = I_ENABLE && ((outstanding - int'(inflight_m)) > 0);
        pop         = exp_valid && I_READY;
        exp_rd      = I_ENABLE && scan_active && (reads < NPIX) && ((outstanding - int'(pop)) < 2);
        check("done",  32'(O_DONE), 32'(done_exp));
        check("busy",  32'(O_BUSY), 32'(scan_active));
        check("valid", 32'(O_VALID), 32'(exp_valid));
        check("rden",  32'(O_FB_READ_ENABLE), 32'(exp_rd));
        check("col",   32'(O_FB_COL), 32'((reads % NPIX) % COLS));
        check("row",   32'(O_FB_ROW), 32'((reads % NPIX) / COLS));
        check("last",  32'(O_LAST), 32'(exp_valid && (xfers == NPIX - 1)));
        if (exp_valid) begin
            check("pixel", 32'(O_PIXEL), 32'(pix(xfers)));
`ifdef FRAME_SCANNER_COORD_EN
            check("pcol", 32'(O_PIXEL_COL), 32'(xfers % COLS));
            check("prow", 32'(O_PIXEL_ROW), 32'(xfers / COLS));
`endif
        end
        s_valid = O_VALID; s_rden = O_FB_READ_ENABLE; s_done = O_DONE; s_busy = O_BUSY;
        s_col = O_FB_COL; s_row = O_FB_ROW; s_pixel = O_PIXEL;
        if (O_FB_READ_ENABLE) dut_reads++;
        if (O_VALID && I_READY) dut_xfers++;
        if (I_RESET && I_ENABLE) begin
            done_exp = 0;
            if (exp_rd) reads++;
            inflight_m = exp_rd;
            if (pop) begin
                xfers++;
                if (xfers == NPIX) begin
                    scan_active = 0;
                    done_exp = 1;
                end
            end
            if (I_START && idle_now) begin
                scan_active = 1; reads = 0; xfers = 0;
            end
        end
    endtask

    task automatic step(input bit en, input bit start, input bit rdy);
        I_ENABLE = en; I_START = start; I_READY = rdy;
        #1;
        observe();
        @(negedge clk);
    endtask

    task automatic start_frame(input bit rdy);
        dut_reads = 0; dut_xfers = 0;
        step(1, 1, rdy);
    endtask

    // mode 0: ready always, 1: ready alternating, 2: random ready/enable/start
    task automatic run_frame(input int mode, input string tag);
        int n;
        bit rdy, en, st;
        n = 0;
        s_done = 0;
        while (!s_done && n < 400) begin
            rdy = 1; en = 1; st = 0;
            if (mode == 1) rdy = ((n % 2) == 0);
            if (mode == 2) begin
                rdy = ($urandom_range(0, 3) != 0);
                en  = ($urandom_range(0, 7) != 0);
                st  = ($urandom_range(0, 15) == 0);
            end
            step(en, st, rdy);
            n++;
        end
        check({tag, "_done"}, 32'(s_done), 32'd1);
        check({tag, "_count"}, 32'(dut_xfers), 32'(NPIX));
    endtask

    initial begin
        int n;
        I_RESET = 0; I_ENABLE = 0; I_START = 0; I_READY = 0;
        model_reset();
        @(negedge clk);
        step(1, 0, 1);
        check_all_zero("reset");
        I_RESET = 1;
        repeat (2) step(1, 0, 1);

        // nominal frame: first valid three cycles after start, 12 back-to-back pixels
        start_frame(1);
        step(1, 0, 1);
        check("t2_first_read", 32'(s_rden), 32'd1);
        check("t2_s2_valid", 32'(s_valid), 32'd0);
        step(1, 0, 1);
        check("t2_s2b_valid", 32'(s_valid), 32'd0);
        step(1, 0, 1);
        check("t2_s3_valid", 32'(s_valid), 32'd1);
        repeat (NPIX - 1) step(1, 0, 1);
        check("t2_count", 32'(dut_xfers), 32'(NPIX));
        step(1, 0, 1);
        check("t2_done", 32'(s_done), 32'd1);
        step(1, 0, 1);

        // backpressure right after start: two reads then stall holding pixel (0,0)
        start_frame(0);
        repeat (10) step(1, 0, 0);
        check("t3_reads", 32'(dut_reads), 32'd2);
        check("t3_valid", 32'(s_valid), 32'd1);
        check("t3_pixel", 32'(s_pixel), 32'(pix(0)));
        run_frame(0, "t3");

        // alternating ready
        start_frame(1);
        run_frame(1, "t4");

        // enable dropped at pixel 5 with a stray start pulse
        start_frame(1);
        n = 0;
        while (dut_xfers < 5 && n < 50) begin step(1, 0, 1); n++; end
        for (int i = 0; i < 5; i++) begin
            step(0, (i == 2), 1);
            check("t5_valid_dis", 32'(s_valid), 32'd0);
            check("t5_busy_dis", 32'(s_busy), 32'd1);
        end
        run_frame(0, "t5");

        // reset asserted mid-cycle during READ
        start_frame(1);
        step(1, 0, 1);
        step(1, 0, 1);
        @(posedge clk);
        #2;
        I_RESET = 0;
        #1;
        check_all_zero("t1_mid");
        model_reset();
        @(negedge clk);
        step(1, 0, 1);
        I_RESET = 1;
        repeat (6) step(1, 0, 1);
        check("t1_no_reads", 32'(dut_reads), 32'd0);

        // reset at pixel 5 then a fresh full frame from (0,0)
        start_frame(1);
        n = 0;
        while (dut_xfers < 5 && n < 50) begin step(1, 0, 1); n++; end
        I_RESET = 0;
        model_reset();
        step(1, 0, 1);
        I_RESET = 1;
        step(1, 0, 1);
        start_frame(1);
        step(1, 0, 1);
        check("t6_rden", 32'(s_rden), 32'd1);
        check("t6_col", 32'(s_col), 32'd0);
        check("t6_row", 32'(s_row), 32'd0);
        run_frame(0, "t6");

        // randomized ready/enable/start over several frames
        for (int f = 0; f < 4; f++) begin
            repeat ($urandom_range(0, 3)) step(1, 0, 1);
            start_frame($urandom_range(0, 1) == 1);
            run_frame(2, "t7");
        end
        step(1, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
